// File: rtl/muldiv_hilo_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional MULDIV_FAST_MULT_EN: single-cycle multiply at accept; divide stays iterative.
module muldiv_hilo_unit #(
  parameter int unsigned ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  functcode,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        is_div, neg_res, neg_a, div_zero;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, rem33;
  logic        div_ge;
  logic [31:0] div_up;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    signed_op = (functcode == F_MULT) || (functcode == F_DIV);
    a_neg     = signed_op & rs_content[31];
    b_neg     = signed_op & rt_content[31];
    a_mag     = a_neg ? (~rs_content + 32'd1) : rs_content;
    b_mag     = b_neg ? (~rt_content + 32'd1) : rt_content;
  end

  // acc holds {partial product, remaining multiplier bits} for MUL and
  // {partial remainder, dividend/quotient bits} for DIV; opnd is the multiplicand/divisor.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    rem33    = acc[63:31];
    div_ge   = rem33 >= {1'b0, opnd};
    div_up   = div_ge ? (rem33[31:0] - opnd) : rem33[31:0];
    prod_fix = neg_res ? (~acc + 64'd1) : acc;
    quo_fix  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_a ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  // A zero divisor leaves |dividend| in the remainder half, so the normal
  // sign fix restores the original rs value in HI; only LO needs forcing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_a    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (functcode)
              F_MULT, F_MULTU: begin
                opnd    <= a_mag;
                neg_res <= a_neg ^ b_neg;
                neg_a   <= a_neg;
                is_div  <= 1'b0;
                cnt     <= '0;
`ifdef MULDIV_FAST_MULT_EN
                acc     <= {32'd0, a_mag} * {32'd0, b_mag};
                state   <= S_FIX;
`else
                acc     <= {32'd0, b_mag};
                state   <= S_MUL;
`endif
              end
              F_DIV, F_DIVU: begin
                opnd     <= b_mag;
                acc      <= {32'd0, a_mag};
                neg_res  <= a_neg ^ b_neg;
                neg_a    <= a_neg;
                div_zero <= (rt_content == '0);
                is_div   <= 1'b1;
                cnt      <= '0;
                state    <= S_DIV;
              end
              F_MTHI:  hi_q <= rs_content;
              F_MTLO:  lo_q <= rs_content;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) state <= S_FIX;
        end
        S_DIV: begin
          acc <= {div_up, acc[30:0], div_ge};
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= div_zero ? '1 : quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: directed vectors plus randomized ops against a plain-arithmetic model.
module tb_muldiv_hilo_unit;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  functcode;
  logic [31:0] rs_content, rt_content;
  logic        busy, done;
  logic [31:0] HI, LO;

  int cmp_count  = 0;
  int fail_count = 0;

  muldiv_hilo_unit dut (
    .clk(clk), .reset(reset), .start(start), .functcode(functcode),
    .rs_content(rs_content), .rt_content(rt_content),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 'x;
    lo = 'x;
    case (f)
      F_MULT:  begin r = sa * sb; hi = r[63:32]; lo = r[31:0]; end
      F_MULTU: begin r = {32'd0, a} * {32'd0, b}; hi = r[63:32]; lo = r[31:0]; end
      F_DIV: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin
          r = sa / sb; lo = r[31:0];
          r = sa % sb; hi = r[31:0];
        end
      end
      F_DIVU: begin
        if (b == 0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  function automatic int lat_of(input logic [5:0] f);
    return (f == F_MULT || f == F_MULTU) ? MUL_LAT : DIV_LAT;
  endfunction

  // Issues one op, counts busy cycles (bounded), returns HI/LO at the done cycle.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int cyc, output int early_done, output bit done_ok);
    @(negedge clk);
    functcode = f; rs_content = a; rt_content = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    early_done = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (done === 1'b1) early_done++;
      @(negedge clk);
    end
    hi = HI;
    lo = LO;
    done_ok = (done === 1'b1);
    @(negedge clk);
    done_ok = done_ok && (done === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; functcode = '0; rs_content = '0; rt_content = '0;
    #13;
    cmp_count++;
    if ({HI, LO, busy, done} !== 66'd0) begin
      fail_count++;
      $display("FAIL reset_state: HI=%h LO=%h busy=%b done=%b expected all zero", HI, LO, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp_count++;
    if ({HI, LO, busy, done} !== 66'd0) begin
      fail_count++;
      $display("FAIL post_reset_idle: HI=%h LO=%h busy=%b done=%b expected all zero", HI, LO, busy, done);
    end
  endtask

  task automatic test_vectors();
    logic [5:0]  vf [7] = '{F_MULT, F_MULTU, F_DIVU, F_DIV, F_DIV, F_DIV, F_DIVU};
    logic [31:0] va [7] = '{32'hFFFFFFFC, 32'h0088888A, 32'h0088888A, 32'hFFFFFFF9, 32'h12345678, 32'h80000000, 32'h9ABCDEF0};
    logic [31:0] vb [7] = '{32'hFFFFFFFB, 32'h0088888B, 32'h0008888B, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] eh [7] = '{32'h00000000, 32'h000048D1, 32'h00088865, 32'hFFFFFFFE, 32'h12345678, 32'h00000000, 32'h9ABCDEF0};
    logic [31:0] el [7] = '{32'h00000014, 32'h5BFB72EE, 32'h0000000F, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] hi, lo;
    int cyc, early;
    bit dok;
    for (int i = 0; i < 7; i++) begin
      run_op(vf[i], va[i], vb[i], hi, lo, cyc, early, dok);
      cmp_count++;
      if (hi !== eh[i] || lo !== el[i]) begin
        fail_count++;
        $display("FAIL vector%0d_result: HI=%h LO=%h expected HI=%h LO=%h", i, hi, lo, eh[i], el[i]);
      end
      cmp_count++;
      if (cyc != lat_of(vf[i])) begin
        fail_count++;
        $display("FAIL vector%0d_latency: busy %0d cycles expected %0d", i, cyc, lat_of(vf[i]));
      end
      cmp_count++;
      if (!dok || early != 0) begin
        fail_count++;
        $display("FAIL vector%0d_done_pulse: single_pulse=%0d early=%0d expected 1/0", i, dok, early);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [5:0]  f;
    logic [31:0] a, b, hi, lo, eh, el;
    int cyc, early, errs;
    bit dok;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        3: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      model(f, a, b, eh, el);
      run_op(f, a, b, hi, lo, cyc, early, dok);
      cmp_count++;
      if (hi !== eh || lo !== el || cyc != lat_of(f) || !dok || early != 0) begin
        fail_count++;
        $display("FAIL random%0d f=%h a=%h b=%h: HI=%h LO=%h cyc=%0d done_ok=%0d expected HI=%h LO=%h cyc=%0d",
                 i, f, a, b, hi, lo, cyc, dok, eh, el, lat_of(f));
      end
    end
  endtask

  task automatic test_mt();
    logic [31:0] hi0, lo0;
    @(negedge clk);
    functcode = F_MTHI; rs_content = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    functcode = F_MTLO; rs_content = 32'hCAFEF00D;
    cmp_count++;
    if (HI !== 32'hDEADBEEF || busy !== 1'b0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL mthi: HI=%h busy=%b done=%b expected DEADBEEF/0/0", HI, busy, done);
    end
    @(negedge clk);
    functcode = 6'h20; rs_content = 32'h55555555;
    cmp_count++;
    if (HI !== 32'hDEADBEEF || LO !== 32'hCAFEF00D || busy !== 1'b0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL mtlo: HI=%h LO=%h busy=%b done=%b expected DEADBEEF/CAFEF00D/0/0", HI, LO, busy, done);
    end
    hi0 = HI; lo0 = LO;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cmp_count++;
    if (HI !== 32'hDEADBEEF || LO !== 32'hCAFEF00D || busy !== 1'b0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL illegal_funct: HI=%h LO=%h busy=%b done=%b expected %h/%h/0/0", HI, LO, busy, done, hi0, lo0);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] a, b, eh, el, hi0, lo0;
    int cyc, disturbed, extra_busy;
    a = $urandom;
    b = 32'($urandom_range(1, 5000));
    model(F_DIV, a, b, eh, el);
    hi0 = HI; lo0 = LO;
    @(negedge clk);
    functcode = F_DIV; rs_content = a; rt_content = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; disturbed = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (HI !== hi0 || LO !== lo0 || done !== 1'b0) disturbed++;
      start = 1'b0;
      if (cyc == 10) begin
        functcode = F_MULTU; rs_content = 32'h0000FFFF; rt_content = 32'h00010001; start = 1'b1;
      end else if (cyc == 20) begin
        functcode = F_MTHI; rs_content = 32'h11111111; start = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    cmp_count++;
    if (disturbed != 0 || cyc != DIV_LAT) begin
      fail_count++;
      $display("FAIL busy_ignore_start: disturbed=%0d cyc=%0d expected 0/%0d", disturbed, cyc, DIV_LAT);
    end
    cmp_count++;
    if (HI !== eh || LO !== el || done !== 1'b1) begin
      fail_count++;
      $display("FAIL busy_div_result: HI=%h LO=%h done=%b expected HI=%h LO=%h done=1", HI, LO, done, eh, el);
    end
    extra_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) extra_busy++;
    end
    cmp_count++;
    if (extra_busy != 0 || HI !== eh || LO !== el) begin
      fail_count++;
      $display("FAIL busy_no_queue: extra=%0d HI=%h LO=%h expected 0/%h/%h", extra_busy, HI, LO, eh, el);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] a, b, hi, lo, eh, el;
    int cyc, early, spurious;
    bit dok;
    run_op(F_MULTU, 32'h12345678, 32'h9ABCDEF0, hi, lo, cyc, early, dok);
    @(negedge clk);
    functcode = F_MULT; rs_content = 32'h7654321F; rt_content = 32'hF0F0F0F1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    cmp_count++;
    if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      fail_count++;
      $display("FAIL async_reset: HI=%h LO=%h busy=%b done=%b expected 0/0/0/0", HI, LO, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) spurious++;
    end
    cmp_count++;
    if (spurious != 0) begin
      fail_count++;
      $display("FAIL reset_abort: %0d cycles with activity expected 0", spurious);
    end
    a = $urandom; b = $urandom;
    model(F_MULT, a, b, eh, el);
    run_op(F_MULT, a, b, hi, lo, cyc, early, dok);
    cmp_count++;
    if (hi !== eh || lo !== el || cyc != MUL_LAT || !dok) begin
      fail_count++;
      $display("FAIL mult_after_reset: HI=%h LO=%h cyc=%0d expected HI=%h LO=%h cyc=%0d", hi, lo, cyc, eh, el, MUL_LAT);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_mt();
    test_random();
    test_start_while_busy();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
